// File: rtl/persp_div.sv
`default_nettype none
// ============================================================================
//  Module   : persp_div
//  Brief    : Perspective-divide stage. Sends w to an external fixed-latency
//             reciprocal unit, holds x/y/z in a pending FIFO until 1/w returns,
//             scales x/y/z by 1/w with saturation and queues the result in a
//             valid/ready output FIFO. A shared occupancy counter guarantees
//             the output FIFO never overflows, so the reciprocal unit is
//             never back-pressured.
//  Revision : 1.0 - initial release
// ============================================================================
module persp_div #(
  parameter int width   = 16,
  parameter int frac    = 8,
  parameter int depth   = 4,
  parameter int rcp_lat = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_v_i,
  output logic             in_ready_o,
  input  logic [width-1:0] x_i,
  input  logic [width-1:0] y_i,
  input  logic [width-1:0] z_i,
  input  logic [width-1:0] w_i,
  output logic             rcp_v_o,
  output logic [width-1:0] rcp_a_o,
  input  logic [width-1:0] rcp_r_i,
  input  logic             rcp_ready_i,
  output logic             out_v_o,
  input  logic             out_ready_i,
  output logic [width-1:0] x_o,
  output logic [width-1:0] y_o,
  output logic [width-1:0] z_o,
  output logic             div0_o,
  output logic             err_o
);

  localparam int c_sh = width - frac;
  localparam int c_aw = $clog2(depth);
  localparam int c_cw = $clog2(depth + 1);
  localparam int c_pw = 2 * width + 1;   // signed product width
  localparam int c_uw = 2 * width;       // unsigned product width

  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam logic [c_cw-1:0] c_depth   = c_cw'(depth);

  // A zero-latency reciprocal would return before its pending entry exists.
  if (frac >= width || depth < 2 || (depth & (depth - 1)) != 0 || rcp_lat < 1) begin : g_bad_cfg
    $error("persp_div: illegal parameter set");
  end

  // Pending FIFO: coordinates waiting for their reciprocal
  logic [width-1:0] r_px [depth];
  logic [width-1:0] r_py [depth];
  logic [width-1:0] r_pz [depth];
  logic             r_pd [depth];
  logic [c_aw-1:0]  r_p_wr, r_p_rd;
  logic [c_cw-1:0]  r_p_cnt;

  // Output FIFO: finished vertices waiting for downstream
  logic [width-1:0] r_ox [depth];
  logic [width-1:0] r_oy [depth];
  logic [width-1:0] r_oz [depth];
  logic             r_od [depth];
  logic [c_aw-1:0]  r_o_wr, r_o_rd;
  logic [c_cw-1:0]  r_o_cnt;

  logic [c_cw-1:0]  r_occ;
  logic             r_err;

  logic w_accept, w_ret, w_spur, w_pop, w_p_empty;
  logic signed [c_pw-1:0] w_x_prod, w_y_prod, w_x_shr, w_y_shr, w_r_sext;
  logic [c_uw-1:0]        w_z_prod, w_z_shr;
  logic [width-1:0]       w_res_x, w_res_y, w_res_z;

  // Signed saturation: the value fits when all bits above the sign bit agree.
  function automatic logic [width-1:0] sat_s(input logic signed [c_pw-1:0] v);
    if (!v[c_pw-1] && (|v[c_pw-2:width-1]))
      sat_s = {1'b0, {(width-1){1'b1}}};
    else if (v[c_pw-1] && !(&v[c_pw-2:width-1]))
      sat_s = {1'b1, {(width-1){1'b0}}};
    else
      sat_s = v[width-1:0];
  endfunction

  function automatic logic [width-1:0] sat_u(input logic [c_uw-1:0] v);
    if (|v[c_uw-1:width]) sat_u = {width{1'b1}};
    else                  sat_u = v[width-1:0];
  endfunction

  assign in_ready_o = rst_ni && (r_occ < c_depth);
  assign w_accept   = in_v_i && in_ready_o;
  assign rcp_v_o    = w_accept;
  assign rcp_a_o    = !w_accept ? '0 : ((w_i == '0) ? {{(width-1){1'b0}}, 1'b1} : w_i);

  assign w_p_empty  = (r_p_cnt == '0);
  assign w_ret      = rcp_ready_i && !w_p_empty;
  assign w_spur     = rcp_ready_i && w_p_empty;

  assign out_v_o    = (r_o_cnt != '0);
  assign w_pop      = out_v_o && out_ready_i;

  // Operands are widened explicitly so the products are exact in c_pw/c_uw bits.
  assign w_r_sext = {{(width+1){1'b0}}, rcp_r_i};
  assign w_x_prod = $signed({{(width+1){r_px[r_p_rd][width-1]}}, r_px[r_p_rd]}) * w_r_sext;
  assign w_y_prod = $signed({{(width+1){r_py[r_p_rd][width-1]}}, r_py[r_p_rd]}) * w_r_sext;
  assign w_z_prod = {{width{1'b0}}, r_pz[r_p_rd]} * {{width{1'b0}}, rcp_r_i};
  assign w_x_shr  = w_x_prod >>> c_sh;
  assign w_y_shr  = w_y_prod >>> c_sh;
  assign w_z_shr  = w_z_prod >> c_sh;

  assign w_res_x = r_pd[r_p_rd] ? '0 : sat_s(w_x_shr);
  assign w_res_y = r_pd[r_p_rd] ? '0 : sat_s(w_y_shr);
  assign w_res_z = r_pd[r_p_rd] ? '0 : sat_u(w_z_shr);

  assign x_o    = out_v_o ? r_ox[r_o_rd] : '0;
  assign y_o    = out_v_o ? r_oy[r_o_rd] : '0;
  assign z_o    = out_v_o ? r_oz[r_o_rd] : '0;
  assign div0_o = out_v_o ? r_od[r_o_rd] : 1'b0;
  assign err_o  = r_err;

  // Pending FIFO: push on accept, pop when the reciprocal returns
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_p_wr  <= '0;
      r_p_rd  <= '0;
      r_p_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_px[r_p_wr] <= x_i;
        r_py[r_p_wr] <= y_i;
        r_pz[r_p_wr] <= z_i;
        r_pd[r_p_wr] <= (w_i == '0);
        r_p_wr       <= r_p_wr + c_ptr_one;
      end
      if (w_ret) r_p_rd <= r_p_rd + c_ptr_one;
      case ({w_accept, w_ret})
        2'b10:   r_p_cnt <= r_p_cnt + c_cnt_one;
        2'b01:   r_p_cnt <= r_p_cnt - c_cnt_one;
        default: ;
      endcase
    end
  end

  // Output FIFO: push the scaled vertex on return, pop on handshake
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_o_wr  <= '0;
      r_o_rd  <= '0;
      r_o_cnt <= '0;
    end else begin
      if (w_ret) begin
        r_ox[r_o_wr] <= w_res_x;
        r_oy[r_o_wr] <= w_res_y;
        r_oz[r_o_wr] <= w_res_z;
        r_od[r_o_wr] <= r_pd[r_p_rd];
        r_o_wr       <= r_o_wr + c_ptr_one;
      end
      if (w_pop) r_o_rd <= r_o_rd + c_ptr_one;
      case ({w_ret, w_pop})
        2'b10:   r_o_cnt <= r_o_cnt + c_cnt_one;
        2'b01:   r_o_cnt <= r_o_cnt - c_cnt_one;
        default: ;
      endcase
    end
  end

  // Total occupancy gates acceptance; sticky error on an unexpected return
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + c_cnt_one;
        2'b01:   r_occ <= r_occ - c_cnt_one;
        default: ;
      endcase
      if (w_spur) r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_persp_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_persp_div
//  Brief    : Self-checking bench for persp_div with a one-cycle reciprocal
//             stub (fixed result or (2^16-1)/a).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_persp_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_v, in_ready;
  logic [15:0] x, y, z, w;
  logic        rcp_v;
  logic [15:0] rcp_a, rcp_r;
  logic        rcp_ready;
  logic        out_v, out_ready;
  logic [15:0] x_o, y_o, z_o;
  logic        div0, err;

  logic        rv = 1'b0;
  logic [15:0] ra = 16'h0;
  logic        use_fixed;
  logic [15:0] stub_r;
  logic        spur;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [15:0] x, y, z, w, r, ea, ex, ey, ez;
    logic        ed;
  } vec_t;

  vec_t tab [6];

  always #5 clk = ~clk;

  persp_div dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_v_i(in_v), .in_ready_o(in_ready),
    .x_i(x), .y_i(y), .z_i(z), .w_i(w),
    .rcp_v_o(rcp_v), .rcp_a_o(rcp_a), .rcp_r_i(rcp_r), .rcp_ready_i(rcp_ready),
    .out_v_o(out_v), .out_ready_i(out_ready),
    .x_o(x_o), .y_o(y_o), .z_o(z_o), .div0_o(div0), .err_o(err)
  );

  // Reciprocal stub with one cycle of latency
  always @(posedge clk) begin
    rv <= rcp_v;
    ra <= rcp_a;
  end
  assign rcp_r     = use_fixed ? stub_r : ((ra == 16'h0) ? 16'h0 : 16'(32'hFFFF / {16'h0, ra}));
  assign rcp_ready = rv | spur;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [15:0] vx, vy, vz, vw, vr, vea,
                              vex, vey, vez, input logic ved);
    vec_t v;
    v.name = n; v.x = vx; v.y = vy; v.z = vz; v.w = vw; v.r = vr;
    v.ea = vea; v.ex = vex; v.ey = vey; v.ez = vez; v.ed = ved;
    return v;
  endfunction

  // Reference arithmetic: {x, y, z, div0}
  function automatic logic [48:0] model(input logic [15:0] mx, my, mz, mw, mr);
    longint px, py, pz;
    logic [15:0] ex, ey, ez;
    if (mw == 16'h0) return 49'h1;
    px = longint'($signed(mx)) * longint'(mr);
    py = longint'($signed(my)) * longint'(mr);
    pz = longint'(mz) * longint'(mr);
    px = px >>> 8;
    py = py >>> 8;
    pz = pz >> 8;
    if (px > 32767) ex = 16'h7FFF; else if (px < -32768) ex = 16'h8000; else ex = px[15:0];
    if (py > 32767) ey = 16'h7FFF; else if (py < -32768) ey = 16'h8000; else ey = py[15:0];
    if (pz > 65535) ez = 16'hFFFF; else ez = pz[15:0];
    return {ex, ey, ez, 1'b0};
  endfunction

  task automatic run_vec(input vec_t v);
    use_fixed = 1'b1; stub_r = v.r; out_ready = 1'b1;
    in_v = 1'b1; x = v.x; y = v.y; z = v.z; w = v.w;
    @(negedge clk);
    check({v.name, "/in_ready"}, in_ready, 1);
    check({v.name, "/rcp_v"}, rcp_v, 1);
    check({v.name, "/rcp_a"}, rcp_a, v.ea);
    tick();
    in_v = 1'b0;
    @(negedge clk);
    check({v.name, "/out_v_early"}, out_v, 0);
    check({v.name, "/rcp_v_idle"}, rcp_v, 0);
    tick();
    @(negedge clk);
    check({v.name, "/out_v"}, out_v, 1);
    check({v.name, "/x_o"}, x_o, v.ex);
    check({v.name, "/y_o"}, y_o, v.ey);
    check({v.name, "/z_o"}, z_o, v.ez);
    check({v.name, "/div0"}, div0, v.ed);
    tick();
    @(negedge clk);
    check({v.name, "/out_v_after"}, out_v, 0);
    tick();
  endtask

  task automatic back_pressure;
    int acc;
    logic [47:0] q [$];
    logic [47:0] e;
    acc = 0;
    out_ready = 1'b0; use_fixed = 1'b1; stub_r = 16'h0100;  // r = 1.0 in Q8.8 keeps values unchanged
    for (int i = 0; i < 6; i++) begin
      in_v = 1'b1;
      x = 16'h1000 + 16'(i);
      y = 16'hF000 + 16'(i * 16);
      z = 16'h0200 + 16'(i);
      w = 16'h0100;
      @(negedge clk);
      if (in_ready) begin
        acc++;
        q.push_back({x, y, z});
      end
      tick();
    end
    in_v = 1'b0;
    check("bp/accepted", acc, 4);
    @(negedge clk);
    check("bp/in_ready_full", in_ready, 0);
    check("bp/rcp_v_full", rcp_v, 0);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = (q.size() != 0) ? q.pop_front() : 48'h0;
      check("bp/out_v", out_v, 1);
      check("bp/x_o", x_o, e[47:32]);
      check("bp/y_o", y_o, e[31:16]);
      check("bp/z_o", z_o, e[15:0]);
      if (k == 0) check("bp/in_ready_pop_cycle", in_ready, 0);
      if (k == 1) check("bp/in_ready_after_pop", in_ready, 1);
      tick();
    end
    @(negedge clk);
    check("bp/drained", out_v, 0);
    tick();
  endtask

  task automatic streaming;
    int sent, got, cyc;
    logic [48:0] sb [$];
    logic [48:0] e;
    logic [15:0] a_eff;
    sent = 0; got = 0; cyc = 0;
    use_fixed = 1'b0;
    while ((sent < 100 || sb.size() != 0) && cyc < 3000) begin
      if (sent < 100) begin
        in_v = ($urandom_range(0, 3) != 0);
        x = 16'($urandom);
        y = 16'($urandom);
        z = 16'($urandom);
        w = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      end else begin
        in_v = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_v && in_ready) begin
        a_eff = (w == 16'h0) ? 16'h1 : w;
        sb.push_back(model(x, y, z, w, 16'(32'hFFFF / {16'h0, a_eff})));
        sent++;
      end
      if (out_v && out_ready) begin
        if (sb.size() == 0) begin
          check("stream/extra_output", 1, 0);
        end else begin
          e = sb.pop_front();
          check("stream/x_o", x_o, e[48:33]);
          check("stream/y_o", y_o, e[32:17]);
          check("stream/z_o", z_o, e[16:1]);
          check("stream/div0", div0, e[0]);
          got++;
        end
      end
      tick();
      cyc++;
    end
    in_v = 1'b0;
    check("stream/received", got, 100);
    check("stream/leftover", sb.size(), 0);
    check("stream/err", err, 0);
  endtask

  task automatic err_and_reset;
    in_v = 1'b0; out_ready = 1'b1; use_fixed = 1'b1; stub_r = 16'h0100;
    tick(); tick();
    @(negedge clk);
    check("err/clear_before", err, 0);
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    @(negedge clk);
    check("err/set", err, 1);
    check("err/out_v", out_v, 0);
    tick();
    @(negedge clk);
    check("err/sticky", err, 1);
    check("err/out_v_still", out_v, 0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_v = 1'b1; x = 16'h0100 * 16'(i + 1); y = 16'h0; z = 16'h0100; w = 16'h0100;
      @(negedge clk);
      check("rst/pre_accept", in_ready, 1);
      tick();
    end
    in_v = 1'b0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst/out_v", out_v, 0);
    check("rst/x_o", x_o, 0);
    check("rst/err", err, 0);
    check("rst/in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/in_ready_after", in_ready, 1);
    check("rst/out_v_after", out_v, 0);
    check("rst/err_after", err, 0);
    tick();
    @(negedge clk);
    check("rst/no_stale_out", out_v, 0);
    check("rst/no_stale_err", err, 0);
    tick();
    run_vec(tab[0]);
  endtask

  initial begin
    tab[0] = mk("single", 16'h0300, 16'hFD00, 16'h0100, 16'h0200, 16'h0080, 16'h0200,
                16'h0180, 16'hFE80, 16'h0080, 1'b0);
    tab[1] = mk("sat",    16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001,
                16'h7FFF, 16'h8000, 16'hFFFF, 1'b0);
    tab[2] = mk("div0",   16'h1234, 16'h5678, 16'h9ABC, 16'h0000, 16'hFFFF, 16'h0001,
                16'h0000, 16'h0000, 16'h0000, 1'b1);
    tab[3] = mk("unity",  16'h0100, 16'h0000, 16'h0200, 16'h0100, 16'h0100, 16'h0100,
                16'h0100, 16'h0000, 16'h0200, 1'b0);
    tab[4] = mk("ashift", 16'hFFFF, 16'h0001, 16'h00FF, 16'h1234, 16'h0001, 16'h1234,
                16'hFFFF, 16'h0000, 16'h0000, 1'b0);
    tab[5] = mk("midsat", 16'hC000, 16'h4000, 16'h4000, 16'h0040, 16'h0400, 16'h0040,
                16'h8000, 16'h7FFF, 16'hFFFF, 1'b0);

    rst_n = 1'b0; in_v = 1'b1; out_ready = 1'b0; spur = 1'b0;
    use_fixed = 1'b1; stub_r = 16'h0;
    x = 16'h0100; y = 16'h0100; z = 16'h0100; w = 16'h0100;
    repeat (3) tick();
    @(negedge clk);
    check("reset/in_ready", in_ready, 0);
    check("reset/rcp_v", rcp_v, 0);
    check("reset/rcp_a", rcp_a, 0);
    check("reset/out_v", out_v, 0);
    check("reset/err", err, 0);
    check("reset/x_o", x_o, 0);
    check("reset/div0", div0, 0);
    tick();
    in_v = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset/in_ready_release", in_ready, 1);
    check("reset/rcp_a_idle", rcp_a, 0);
    tick();

    for (int i = 0; i < 6; i++) run_vec(tab[i]);
    back_pressure();
    streaming();
    err_and_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
